// File: rtl/t_inst_pkg.sv
// Shared types and constants for the t_inst test drivers: state encoding,
// LFSR taps, trace/error widths and a saturating error accumulator.
package t_inst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam int          TRACE_W   = 128;
    localparam int          ERR_W     = 8;

    // Adds up to two errors per cycle and pins at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] err_sat_add(input logic [ERR_W-1:0] acc,
                                                     input logic [1:0]       inc);
        logic [ERR_W:0] sum;
        sum = {1'b0, acc} + {{(ERR_W - 1){1'b0}}, inc};
        return sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    endfunction

endpackage

// File: rtl/t_inst_lfsr.sv
// Galois LFSR (right-shifting) with synchronous reload and advance enable.
// Shared by the t_inst family of stimulus drivers.
module t_inst_lfsr
    import t_inst_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH - 1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] lfsr_d, lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (adv) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/t_inst_drv_chk.sv
// Stimulus driver / response checker for the t_inst_b port list.
// Define T_INST_DRV_WIDE_TRACE_EN to drive the 128-bit trace buses.
module t_inst_drv_chk
    import t_inst_pkg::*;
#(
    parameter int          CYCLES = 64,
    parameter logic [31:0] SEED   = 32'h0000_0001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               i_seq,
    output logic               i_com,
    output logic [1:0]         i2_com,
    output logic [TRACE_W-1:0] wide_for_trace,
    output logic [TRACE_W-1:0] wide_for_trace_2,
    input  logic               o_seq_d1r,
    input  logic               o_com,
    input  logic [1:0]         o2_com,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count
);

    state_e             state_d, state_q;
    logic [15:0]        cnt_d, cnt_q;
    logic [ERR_W-1:0]   err_d, err_q;
    logic               prev_seq_d, prev_seq_q;
    logic               seq_vld_d, seq_vld_q;
    logic               load, run, flush, com_err, seq_err;
    logic [31:0]        lfsr;

    t_inst_lfsr #(.WIDTH(32), .TAPS(LFSR_TAPS), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .adv   (run),
        .q     (lfsr)
    );

    assign run   = (state_q == ST_RUN);
    assign flush = (state_q == ST_FLUSH);

    // Drives are decoded from registered state only, so they move on clk edges.
    assign i_seq  = run & lfsr[0];
    assign i_com  = run & lfsr[1];
    assign i2_com = run ? lfsr[3:2] : 2'b00;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN:   if (cnt_q == 16'(CYCLES - 1)) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        com_err = run && ((o_com != ~i_com) || (o2_com != ~i2_com));
        // FLUSH exists only to check the response to the last RUN cycle's i_seq.
        seq_err = ((run && seq_vld_q) || flush) && (o_seq_d1r != ~prev_seq_q);

        cnt_d      = load ? 16'd0 : (run ? cnt_q + 16'd1 : cnt_q);
        err_d      = load ? '0 : err_sat_add(err_q, {1'b0, com_err} + {1'b0, seq_err});
        prev_seq_d = run ? i_seq : prev_seq_q;
        seq_vld_d  = load ? 1'b0 : (run ? 1'b1 : seq_vld_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= '0;
            prev_seq_q <= 1'b0;
            seq_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            prev_seq_q <= prev_seq_d;
            seq_vld_q  <= seq_vld_d;
        end
    end

`ifdef T_INST_DRV_WIDE_TRACE_EN
    logic [TRACE_W-1:0] trace;
    assign trace            = {lfsr, ~lfsr, lfsr[15:0], lfsr[31:16], 16'h0000, cnt_q};
    assign wide_for_trace   = run ? trace  : '0;
    assign wide_for_trace_2 = run ? ~trace : '0;
`else
    logic lfsr_hi_unused;
    assign lfsr_hi_unused   = ^lfsr[31:4];
    assign wide_for_trace   = '0;
    assign wide_for_trace_2 = '0;
`endif

    assign busy      = run | flush;
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;

endmodule

// File: tb/tb_t_inst_drv_chk.sv
// Directed bench for t_inst_drv_chk: behavioural DUT models on the response
// side, hand-computed LFSR vectors and reference error counts.
module tb_t_inst_drv_chk;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         start_s = 1'b0;
    logic         i_seq, i_com, o_seq_d1r, o_com, busy, done, pass;
    logic [1:0]   i2_com, o2_com;
    logic [127:0] wide, wide2;
    logic [7:0]   err_count;
    logic         i_seq_s, i_com_s, o_seq_s, o_com_s, busy_s, done_s, pass_s;
    logic [1:0]   i2_com_s, o2_com_s;
    logic [127:0] wide_unused_s, wide2_unused_s;
    logic [7:0]   err_s;

    int tests = 0;
    int fails = 0;
    int mode  = 0;
    logic s1, s2, ws1;
    logic [3:0] exp_drv [5] = '{4'h1, 4'h3, 4'h2, 4'h1, 4'h3};

    always #5 clk = ~clk;

    t_inst_drv_chk #(.CYCLES(64), .SEED(32'h1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .i_seq(i_seq), .i_com(i_com), .i2_com(i2_com),
        .wide_for_trace(wide), .wide_for_trace_2(wide2),
        .o_seq_d1r(o_seq_d1r), .o_com(o_com), .o2_com(o2_com),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
    );

    t_inst_drv_chk #(.CYCLES(200), .SEED(32'h1)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .i_seq(i_seq_s), .i_com(i_com_s), .i2_com(i2_com_s),
        .wide_for_trace(wide_unused_s), .wide_for_trace_2(wide2_unused_s),
        .o_seq_d1r(o_seq_s), .o_com(o_com_s), .o2_com(o2_com_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s)
    );

    // Modelled DUT: 0 ideal, 1 o_com stuck 0, 2 o_seq_d1r with 2-cycle latency.
    always @(posedge clk) begin
        s1  <= ~i_seq;
        s2  <= s1;
        ws1 <= i_seq_s;
    end

    always_comb begin
        o_com     = ~i_com;
        o2_com    = ~i2_com;
        o_seq_d1r = s1;
        if (mode == 1) o_com = 1'b0;
        if (mode == 2) o_seq_d1r = s2;
    end

    // Every response wrong on the saturation instance.
    assign o_com_s  = i_com_s;
    assign o2_com_s = i2_com_s;
    assign o_seq_s  = ws1;

    function automatic logic [31:0] nxt(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({busy, done, pass, err_count, i_seq, i_com, i2_com} !== 15'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, done, pass, err_count, i_seq, i_com, i2_com});
        end
        tests++;
        if ({wide, wide2} !== 256'h0) begin
            fails++;
            $display("FAIL reset_trace: got %h expected 0", {wide, wide2});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL idle_hold: busy/done got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_ideal();
        mode = 0;
        pulse_start();
        for (int j = 0; j < 5; j++) begin
            tests++;
            if ({i2_com, i_com, i_seq} !== exp_drv[j] || busy !== 1'b1) begin
                fails++;
                $display("FAIL drive_c%0d: got drv=%h busy=%b expected drv=%h busy=1",
                         j, {i2_com, i_com, i_seq}, busy, exp_drv[j]);
            end
            if (j == 0) begin
                tests++;
`ifdef T_INST_DRV_WIDE_TRACE_EN
                if (wide !== {32'h1, 32'hFFFF_FFFE, 32'h0001_0000, 32'h0} || wide2 !== ~wide) begin
`else
                if (wide !== 128'h0 || wide2 !== 128'h0) begin
`endif
                    fails++;
                    $display("FAIL trace_c0: got %h / %h", wide, wide2);
                end
            end
            @(negedge clk);
        end
        repeat (59) @(negedge clk);
        tests++;
        if ({busy, done, i_seq, i_com, i2_com} !== 6'b100000) begin
            fails++;
            $display("FAIL flush_state: got %b expected 100000", {busy, done, i_seq, i_com, i2_com});
        end
        @(negedge clk);
        tests++;
        if ({busy, done, pass, err_count} !== {3'b011, 8'd0}) begin
            fails++;
            $display("FAIL ideal_done: busy/done/pass/err got %b/%b/%b/%0d expected 0/1/1/0",
                     busy, done, pass, err_count);
        end
        repeat (3) @(negedge clk);
        tests++;
        if ({done, pass} !== 2'b11) begin
            fails++;
            $display("FAIL done_hold: done/pass got %b expected 11", {done, pass});
        end
    endtask

    task automatic test_stuck();
        logic [31:0] s;
        int exp_err;
        bit ok;
        s = 32'h1;
        exp_err = 0;
        for (int k = 0; k < 64; k++) begin
            if (s[1] == 1'b0) exp_err++;
            s = nxt(s);
        end
        mode = 1;
        pulse_start();
        wait_done(200, ok);
        tests++;
        if (!ok || err_count !== 8'(exp_err) || pass !== 1'b0) begin
            fails++;
            $display("FAIL stuck_com: done=%b err=%0d pass=%b expected done=1 err=%0d pass=0",
                     ok, err_count, pass, exp_err);
        end
    endtask

    task automatic test_lat2();
        logic [31:0] s;
        logic prev;
        int exp_err;
        bit ok;
        s = 32'h1;
        prev = 1'b0;
        exp_err = 0;
        for (int k = 0; k < 64; k++) begin
            if (s[0] != prev) exp_err++;
            prev = s[0];
            s = nxt(s);
        end
        mode = 2;
        pulse_start();
        wait_done(200, ok);
        tests++;
        if (!ok || err_count !== 8'(exp_err) || pass !== 1'b0) begin
            fails++;
            $display("FAIL seq_lat2: done=%b err=%0d pass=%b expected done=1 err=%0d pass=0",
                     ok, err_count, pass, exp_err);
        end
    endtask

    task automatic test_restart();
        logic [63:0] seq1;
        logic [63:0] seq2;
        mode = 1;
        pulse_start();
        for (int j = 0; j < 64; j++) begin
            seq1[j] = i_seq;
            if (j == 20) start = 1'b1;
            if (j == 21) start = 1'b0;
            @(negedge clk);
        end
        tests++;
        if ({busy, done} !== 2'b10) begin
            fails++;
            $display("FAIL ignore_start: busy/done got %b expected 10 (flush)", {busy, done});
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || err_count == 8'd0) begin
            fails++;
            $display("FAIL first_pass: done=%b err=%0d expected done=1 err>0", done, err_count);
        end
        start = 1'b1;
        mode = 0;
        @(negedge clk) start = 1'b0;
        tests++;
        if ({busy, done, pass, err_count} !== {3'b100, 8'd0}) begin
            fails++;
            $display("FAIL restart_clear: busy/done/pass/err got %b/%b/%b/%0d expected 1/0/0/0",
                     busy, done, pass, err_count);
        end
        for (int j = 0; j < 64; j++) begin
            seq2[j] = i_seq;
            @(negedge clk);
        end
        tests++;
        if (seq2 !== seq1) begin
            fails++;
            $display("FAIL restart_seq: got %h expected %h", seq2, seq1);
        end
        @(negedge clk);
        tests++;
        if ({done, pass} !== 2'b11) begin
            fails++;
            $display("FAIL restart_pass: done/pass got %b expected 11", {done, pass});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        mode = 0;
        pulse_start();
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, pass, err_count, i_seq, i_com, i2_com} !== 15'h0) begin
            fails++;
            $display("FAIL async_reset: got %h expected 0",
                     {busy, done, pass, err_count, i_seq, i_com, i2_com});
        end
        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        wait_done(200, ok);
        tests++;
        if (!ok || pass !== 1'b1 || err_count !== 8'd0) begin
            fails++;
            $display("FAIL post_reset_pass: done=%b pass=%b err=%0d expected 1/1/0",
                     ok, pass, err_count);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        @(negedge clk) start_s = 1'b1;
        @(negedge clk) start_s = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (err_s !== 8'd19) begin
            fails++;
            $display("FAIL sat_ramp: err got %0d expected 19", err_s);
        end
        repeat (130) @(negedge clk);
        tests++;
        if (err_s !== 8'd255 || busy_s !== 1'b1) begin
            fails++;
            $display("FAIL sat_mid: err=%0d busy=%b expected 255/1", err_s, busy_s);
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_s) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok || err_s !== 8'd255 || pass_s !== 1'b0) begin
            fails++;
            $display("FAIL sat_end: done=%b err=%0d pass=%b expected 1/255/0", ok, err_s, pass_s);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck();
        test_lat2();
        test_restart();
        test_reset_mid();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
